// File: rtl/inter_req_arbiter.sv
// Round-robin arbiter that shares the interboard transmit port between the
// move, draw, select and turn-end handlers. Each request waits in its own slot.
module inter_req_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interboard_rst,
  input  logic [3:0]  req_en,
  input  logic [3:0]  req_move_dir,
  input  logic [19:0] req_block_x,
  input  logic [11:0] req_block_y,
  input  logic [15:0] req_msg_type,
  input  logic [23:0] req_card,
  input  logic [11:0] req_sel_len,
  input  logic        inter_ready,
  output logic        ctrl_en,
  output logic        ctrl_move_dir,
  output logic [4:0]  ctrl_block_x,
  output logic [2:0]  ctrl_block_y,
  output logic [3:0]  ctrl_msg_type,
  output logic [5:0]  ctrl_card,
  output logic [2:0]  ctrl_sel_len,
  output logic [3:0]  req_ready,
  output logic [3:0]  req_fail,
  output logic [3:0]  pending,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, FAIL} state_t;

  state_t           state;
  logic [1:0]       last;
  logic [CNT_W-1:0] cnt;
  logic             sync_rst;

  logic [3:0] slot_valid;
  logic       slot_dir  [4];
  logic [4:0] slot_x    [4];
  logic [2:0] slot_y    [4];
  logic [3:0] slot_msg  [4];
  logic [5:0] slot_card [4];
  logic [2:0] slot_len  [4];

  logic [3:0] win_onehot;
  logic [3:0] release_slot;
  logic       grant_found;
  logic [1:0] grant_idx;
  logic [1:0] cand;

  assign sync_rst     = rst | interboard_rst;
  assign pending      = slot_valid;
  assign win_onehot   = 4'b0001 << last;
  assign release_slot = ((state == DONE) || (state == FAIL)) ? win_onehot : 4'b0000;

  // A request into a releasing slot is accepted; into any other full slot it is dropped.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      slot_valid   <= 4'b0000;
      err_overflow <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        slot_dir[i]  <= 1'b0;
        slot_x[i]    <= 5'd0;
        slot_y[i]    <= 3'd0;
        slot_msg[i]  <= 4'd0;
        slot_card[i] <= 6'd0;
        slot_len[i]  <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_en[i] && (!slot_valid[i] || release_slot[i])) begin
          slot_valid[i] <= 1'b1;
          slot_dir[i]   <= req_move_dir[i];
          slot_x[i]     <= req_block_x[5*i +: 5];
          slot_y[i]     <= req_block_y[3*i +: 3];
          slot_msg[i]   <= req_msg_type[4*i +: 4];
          slot_card[i]  <= req_card[6*i +: 6];
          slot_len[i]   <= req_sel_len[3*i +: 3];
        end else if (req_en[i]) begin
          err_overflow <= 1'b1;
        end else if (release_slot[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Search starts just after the previous winner, so the previous winner is tried last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last;
    cand        = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!grant_found && slot_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state         <= IDLE;
      last          <= 2'd3;
      cnt           <= '0;
      ctrl_en       <= 1'b0;
      ctrl_move_dir <= 1'b0;
      ctrl_block_x  <= 5'd0;
      ctrl_block_y  <= 3'd0;
      ctrl_msg_type <= 4'd0;
      ctrl_card     <= 6'd0;
      ctrl_sel_len  <= 3'd0;
      req_ready     <= 4'b0000;
      req_fail      <= 4'b0000;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      ctrl_en   <= 1'b0;
      req_ready <= 4'b0000;
      req_fail  <= 4'b0000;
      case (state)
        IDLE: begin
          if (grant_found) begin
            last          <= grant_idx;
            ctrl_move_dir <= slot_dir[grant_idx];
            ctrl_block_x  <= slot_x[grant_idx];
            ctrl_block_y  <= slot_y[grant_idx];
            ctrl_msg_type <= slot_msg[grant_idx];
            ctrl_card     <= slot_card[grant_idx];
            ctrl_sel_len  <= slot_len[grant_idx];
            ctrl_en       <= 1'b1;
            busy          <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A ready in the final counted cycle still wins over the timeout.
          if (inter_ready) begin
            req_ready <= win_onehot;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            req_fail <= win_onehot;
            state    <= FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAIL: begin
          err_timeout <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inter_req_arbiter.sv
// Bench for inter_req_arbiter: directed scenarios plus a randomized run against
// a cycle-numbered transaction model of slots, round-robin order and timeouts.
module tb_inter_req_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        interboard_rst = 1'b0;
  logic [3:0]  req_en = '0;
  logic [3:0]  req_move_dir = '0;
  logic [19:0] req_block_x = '0;
  logic [11:0] req_block_y = '0;
  logic [15:0] req_msg_type = '0;
  logic [23:0] req_card = '0;
  logic [11:0] req_sel_len = '0;
  logic        inter_ready = 1'b0;
  logic        ctrl_en, ctrl_move_dir;
  logic [4:0]  ctrl_block_x;
  logic [2:0]  ctrl_block_y;
  logic [3:0]  ctrl_msg_type;
  logic [5:0]  ctrl_card;
  logic [2:0]  ctrl_sel_len;
  logic [3:0]  req_ready, req_fail, pending;
  logic        busy, err_overflow, err_timeout;

  int checks = 0;
  int errors = 0;

  inter_req_arbiter #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
    .req_en(req_en), .req_move_dir(req_move_dir), .req_block_x(req_block_x),
    .req_block_y(req_block_y), .req_msg_type(req_msg_type), .req_card(req_card),
    .req_sel_len(req_sel_len), .inter_ready(inter_ready),
    .ctrl_en(ctrl_en), .ctrl_move_dir(ctrl_move_dir), .ctrl_block_x(ctrl_block_x),
    .ctrl_block_y(ctrl_block_y), .ctrl_msg_type(ctrl_msg_type), .ctrl_card(ctrl_card),
    .ctrl_sel_len(ctrl_sel_len), .req_ready(req_ready), .req_fail(req_fail),
    .pending(pending), .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] mkf(logic d, logic [4:0] x, logic [2:0] y,
                                      logic [3:0] m, logic [5:0] c, logic [2:0] l);
    return {d, x, y, m, c, l};
  endfunction

  function automatic logic [21:0] ctrl_word();
    return {ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card, ctrl_sel_len};
  endfunction

  task automatic set_req(input int i, input logic [21:0] f);
    req_en[i]              = 1'b1;
    req_move_dir[i]        = f[21];
    req_block_x[5*i +: 5]  = f[20:16];
    req_block_y[3*i +: 3]  = f[15:13];
    req_msg_type[4*i +: 4] = f[12:9];
    req_card[6*i +: 6]     = f[8:3];
    req_sel_len[3*i +: 3]  = f[2:0];
  endtask

  // Leaves the bench at cycle 0 of a freshly reset arbiter.
  task automatic do_reset();
    rst = 1'b1;
    req_en = '0;
    inter_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ctrl_en(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (ctrl_en) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_ctrl_en got %b want 0", ctrl_en); end
    checks++; if (ctrl_word() !== 22'd0) begin errors++; $display("[TB] FAIL reset_fields got %h want 0", ctrl_word()); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (req_fail !== 4'b0) begin errors++; $display("[TB] FAIL reset_req_fail got %b want 0000", req_fail); end
    checks++; if (pending !== 4'b0) begin errors++; $display("[TB] FAIL reset_pending got %b want 0000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_overflow got %b want 0", err_overflow); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_timeout got %b want 0", err_timeout); end
  endtask

  task automatic test_single_move();
    do_reset();
    set_req(0, mkf(1'b1, 5'd7, 3'd2, 4'd3, 6'd12, 3'd4));
    tick(); req_en = '0;
    checks++; if (pending !== 4'b0001) begin errors++; $display("[TB] FAIL single_pending got %b want 0001", pending); end
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("[TB] FAIL single_en_c1 got %b want 0", ctrl_en); end
    tick();
    checks++; if (ctrl_en !== 1'b1) begin errors++; $display("[TB] FAIL single_en_c2 got %b want 1", ctrl_en); end
    checks++; if ({ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card} !== {5'd7, 3'd2, 4'd3, 6'd12})
      begin errors++; $display("[TB] FAIL single_fields got %h want %h", {ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card}, {5'd7, 3'd2, 4'd3, 6'd12}); end
    tick();
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("[TB] FAIL single_en_c3 got %b want 0", ctrl_en); end
    tick(); tick();
    inter_ready = 1'b1;
    tick(); inter_ready = 1'b0;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready_c6 got %b want 0001", req_ready); end
    tick();
    checks++; if ({busy, req_ready, pending} !== 9'd0) begin errors++; $display("[TB] FAIL single_c7 busy/ready/pending got %b want 0", {busy, req_ready, pending}); end
    checks++; if (ctrl_card !== 6'd12) begin errors++; $display("[TB] FAIL single_hold_card got %0d want 12", ctrl_card); end
  endtask

  task automatic test_simultaneous();
    int order [6] = '{0, 1, 2, 3, 0, 2};
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, mkf(1'b0, 5'(i + 1), 3'(i), 4'(i + 2), 6'(10 + i), 3'(i)));
    tick(); req_en = '0;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) begin
        set_req(0, mkf(1'b1, 5'd20, 3'd0, 4'd1, 6'd20, 3'd1));
        set_req(2, mkf(1'b1, 5'd22, 3'd2, 4'd1, 6'd22, 3'd1));
        tick(); req_en = '0;
      end
      wait_ctrl_en(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL simul_grant%0d got no ctrl_en want ctrl_en", g); end
      checks++; if (ctrl_card !== 6'((g < 4 ? 10 : 20) + order[g]))
        begin errors++; $display("[TB] FAIL simul_card%0d got %0d want %0d", g, ctrl_card, (g < 4 ? 10 : 20) + order[g]); end
      tick(); tick();
      inter_ready = 1'b1;
      tick(); inter_ready = 1'b0;
      checks++; if (req_ready !== 4'(1 << order[g])) begin errors++; $display("[TB] FAIL simul_ready%0d got %b want %b", g, req_ready, 4'(1 << order[g])); end
      tick();
    end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    set_req(0, mkf(1'b0, 5'd1, 3'd1, 4'd1, 6'd30, 3'd1));
    set_req(1, mkf(1'b0, 5'd2, 3'd2, 4'd2, 6'd31, 3'd2));
    tick(); req_en = '0;
    for (int g = 0; g < 8; g++) begin
      wait_ctrl_en(ok);
      checks++; if (!ok || ctrl_card !== 6'(30 + g % 2))
        begin errors++; $display("[TB] FAIL fair_grant%0d got card %0d (en %b) want %0d", g, ctrl_card, ok, 30 + g % 2); end
      tick(); inter_ready = 1'b1;
      tick(); inter_ready = 1'b0;
      checks++; if (req_ready !== 4'(1 << (g % 2))) begin errors++; $display("[TB] FAIL fair_ready%0d got %b want %b", g, req_ready, 4'(1 << (g % 2))); end
      set_req(g % 2, mkf(1'b0, 5'(1 + g % 2), 3'(1 + g % 2), 4'(1 + g % 2), 6'(30 + g % 2), 3'(1 + g % 2)));
      tick(); req_en = '0;
    end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL fair_overflow got %b want 0", err_overflow); end
  endtask

  task automatic test_overflow();
    int extra = 0;
    do_reset();
    set_req(2, mkf(1'b0, 5'd3, 3'd3, 4'd3, 6'd5, 3'd3));
    tick();
    set_req(2, mkf(1'b1, 5'd9, 3'd1, 4'd9, 6'd9, 3'd5));
    tick(); req_en = '0;
    checks++; if (ctrl_en !== 1'b1 || ctrl_card !== 6'd5) begin errors++; $display("[TB] FAIL ovf_card got %0d (en %b) want 5", ctrl_card, ctrl_en); end
    tick();
    set_req(2, mkf(1'b1, 5'd9, 3'd1, 4'd9, 6'd9, 3'd5));
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b want 1", err_overflow); end
    tick(); req_en = '0; inter_ready = 1'b1;
    tick(); inter_ready = 1'b0;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL ovf_ready got %b want 0100", req_ready); end
    for (int n = 0; n < 10; n++) begin
      tick();
      extra += int'(req_ready[2]) + int'(ctrl_en);
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL ovf_extra got %0d want 0", extra); end
    checks++; if (pending !== 4'b0 || err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_after got pending %b ovf %b want 0000 1", pending, err_overflow); end
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    set_req(0, mkf(1'b0, 5'd4, 3'd4, 4'd4, 6'd40, 3'd4));
    set_req(1, mkf(1'b1, 5'd5, 3'd5, 4'd5, 6'd41, 3'd5));
    tick(); req_en = '0;
    tick();
    checks++; if (ctrl_en !== 1'b1 || ctrl_card !== 6'd40) begin errors++; $display("[TB] FAIL tout_grant got card %0d (en %b) want 40", ctrl_card, ctrl_en); end
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (req_fail != 4'b0 || req_ready != 4'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("[TB] FAIL tout_early got %0d pulses want 0", early); end
    tick();
    checks++; if (req_fail !== 4'b0001 || req_ready !== 4'b0) begin errors++; $display("[TB] FAIL tout_fail got fail %b ready %b want 0001 0000", req_fail, req_ready); end
    tick();
    checks++; if (err_timeout !== 1'b1 || req_fail !== 4'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL tout_after got err %b fail %b busy %b want 1 0000 0", err_timeout, req_fail, busy); end
    tick();
    checks++; if (ctrl_en !== 1'b1 || ctrl_card !== 6'd41) begin errors++; $display("[TB] FAIL tout_next got card %0d (en %b) want 41", ctrl_card, ctrl_en); end
    tick(); inter_ready = 1'b1;
    tick(); inter_ready = 1'b0;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL tout_next_ready got %b want 0010", req_ready); end
  endtask

  task automatic test_reset_mid_wait();
    int late;
    for (int src = 0; src < 2; src++) begin
      late = 0;
      do_reset();
      for (int i = 0; i < 3; i++) set_req(i, mkf(1'b1, 5'(i + 1), 3'(i + 1), 4'(i + 1), 6'(50 + i), 3'(i + 1)));
      tick(); req_en = '0;
      tick(); tick();
      set_req(0, mkf(1'b0, 5'd0, 3'd0, 4'd0, 6'd1, 3'd0));
      tick(); req_en = '0;
      if (src == 0) rst = 1'b1; else interboard_rst = 1'b1;
      tick();
      rst = 1'b0; interboard_rst = 1'b0; inter_ready = 1'b1;
      checks++; if ({ctrl_en, ctrl_word(), req_ready, req_fail, pending, busy, err_overflow, err_timeout} !== 42'd0)
        begin errors++; $display("[TB] FAIL rst_mid%0d outputs got %h want 0", src, {ctrl_en, ctrl_word(), req_ready, req_fail, pending, busy, err_overflow, err_timeout}); end
      for (int n = 0; n < 6; n++) begin
        tick(); inter_ready = 1'b0;
        if (req_ready != 4'b0 || req_fail != 4'b0 || ctrl_en) late++;
      end
      checks++; if (late !== 0) begin errors++; $display("[TB] FAIL rst_mid%0d late_pulses got %0d want 0", src, late); end
    end
  endtask

  task automatic test_random();
    logic [3:0]  m_valid = '0;
    logic [21:0] m_f [4];
    logic [21:0] m_ctrl = '0;
    logic [21:0] f;
    bit m_ovf = 0, m_tout = 0, active = 0, end_fail = 0;
    int m_last = 3, cur = 0, gc = -1, ready_c = -1, end_c = -1, idle_from = 0, d;
    logic [3:0] exp_rdy, exp_fl;
    do_reset();
    for (int i = 0; i < 4; i++) m_f[i] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_rdy = (active && cyc == end_c && !end_fail) ? 4'(1 << cur) : 4'b0;
      exp_fl  = (active && cyc == end_c && end_fail) ? 4'(1 << cur) : 4'b0;
      checks++; if (ctrl_en !== (active && cyc == gc)) begin errors++; $display("[TB] FAIL rand_ctrl_en cyc %0d got %b want %b", cyc, ctrl_en, active && cyc == gc); end
      checks++; if (ctrl_word() !== m_ctrl) begin errors++; $display("[TB] FAIL rand_fields cyc %0d got %h want %h", cyc, ctrl_word(), m_ctrl); end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rand_ready cyc %0d got %b want %b", cyc, req_ready, exp_rdy); end
      checks++; if (req_fail !== exp_fl) begin errors++; $display("[TB] FAIL rand_fail cyc %0d got %b want %b", cyc, req_fail, exp_fl); end
      checks++; if (pending !== m_valid) begin errors++; $display("[TB] FAIL rand_pending cyc %0d got %b want %b", cyc, pending, m_valid); end
      checks++; if (busy !== (active && cyc >= gc && cyc <= end_c)) begin errors++; $display("[TB] FAIL rand_busy cyc %0d got %b", cyc, busy); end
      checks++; if ({err_overflow, err_timeout} !== {m_ovf, m_tout}) begin errors++; $display("[TB] FAIL rand_errs cyc %0d got %b want %b", cyc, {err_overflow, err_timeout}, {m_ovf, m_tout}); end

      if (!active && cyc >= idle_from && m_valid != 4'b0) begin
        for (int k = 1; k <= 4 && !active; k++) begin
          if (m_valid[(m_last + k) % 4]) begin
            cur = (m_last + k) % 4;
            active = 1'b1;
          end
        end
        m_last = cur;
        m_ctrl = m_f[cur];
        gc = cyc + 1;
        d = int'($urandom_range(0, T + 2));
        end_fail = (d >= T);
        ready_c = end_fail ? -1 : gc + 1 + d;
        end_c = end_fail ? gc + 1 + T : ready_c + 1;
      end

      if (active && cyc == ready_c) inter_ready = 1'b1;
      else if (active && cyc > gc && cyc < end_c) inter_ready = 1'b0;
      else inter_ready = ($urandom_range(0, 3) == 0);

      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          f = 22'($urandom);
          set_req(i, f);
          if (!m_valid[i] || (active && cyc == end_c && i == cur)) begin
            m_valid[i] = 1'b1;
            m_f[i] = f;
          end else begin
            m_ovf = 1'b1;
          end
        end else begin
          req_en[i] = 1'b0;
        end
      end
      if (active && cyc == end_c) begin
        if (!req_en[cur]) m_valid[cur] = 1'b0;
        if (end_fail) m_tout = 1'b1;
        active = 1'b0;
        idle_from = cyc + 1;
      end
      tick();
    end
    req_en = '0;
    inter_ready = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_move();
    test_simultaneous();
    test_fairness();
    test_overflow();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inter_req_arbiter.md
# inter_req_arbiter

Shares the single interboard transmit port between the game-control handlers (move, draw, select, turn-end) of one board. Each handler issues a one-cycle request with its message fields; the arbiter captures it in a per-requester pending slot and grants the port round-robin. It then drives one transfer at a time to the interboard sender and waits for `inter_ready`. It returns a completion or failure pulse to the originating handler.

## Interface
- `TIMEOUT_CYC`, default 100_000_000: cycles spent in WAIT before a transfer is aborted. Must be ≥ 1.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `interboard_rst` input 1: synchronous, active-high. Same effect as `rst`.
- `req_en` input 4: per-requester request pulse. Bit 0 = move, 1 = draw, 2 = select, 3 = turn.
- `req_move_dir` input 4: bit i belongs to requester i.
- `req_block_x` input 20: 5 bits per requester; requester i uses `[5i+4:5i]`.
- `req_block_y` input 12: 3 bits per requester.
- `req_msg_type` input 16: 4 bits per requester.
- `req_card` input 24: 6 bits per requester.
- `req_sel_len` input 12: 3 bits per requester.
- `inter_ready` input 1: pulse from the interboard sender when the current transfer is complete.
- `ctrl_en` output 1: one-cycle send strobe to the interboard sender.
- `ctrl_move_dir` output 1, `ctrl_block_x` output 5, `ctrl_block_y` output 3, `ctrl_msg_type` output 4, `ctrl_card` output 6, `ctrl_sel_len` output 3: registered fields of the granted request.
- `req_ready` output 4: one-cycle completion pulse to requester i.
- `req_fail` output 4: one-cycle timeout pulse to requester i.
- `pending` output 4: pending-slot valid bits.
- `busy` output 1: high when the state is not IDLE.
- `err_overflow` output 1: sticky. Set when a request arrives while that requester's slot is already valid.
- `err_timeout` output 1: sticky. Set on any timeout.

## Operation
- **Pending slots**
  - One slot per requester, holding valid plus fields.
  - When `req_en[i]` is high and the slot is empty, capture the fields and set valid on the next edge.
  - When `req_en[i]` is high and the slot is valid (including a slot currently granted), keep the old contents and set `err_overflow`.
  - Exception: in the DONE or FAIL cycle for the winner, a new `req_en[winner]` is accepted. The capture overrides the clear.
- **Round-robin arbitration**
  - Pointer `last` resets to 3.
  - The search order is `last+1, last+2, …` modulo 4. The first valid slot wins, and `last` is set to the winner.
- **State machine**
  - IDLE: if any pending bit is set, pick the winner, load all `ctrl_*` fields from its slot, and go to SEND. Otherwise stay in IDLE.
  - SEND: `ctrl_en` = 1, clear the timeout counter, go to WAIT.
  - WAIT: on `inter_ready`, go to DONE. Otherwise increment the counter. When the counter reaches `TIMEOUT_CYC − 1` with no `inter_ready`, go to FAIL.
  - DONE: `req_ready[winner]` = 1, clear the winner's slot, go to IDLE.
  - FAIL: `req_fail[winner]` = 1, clear the winner's slot, set `err_timeout`, go to IDLE.
- `inter_ready` outside WAIT is ignored.
- `ctrl_*` fields hold their value from the IDLE load until the next load. Fields are zero after reset.
- Only the winner's slot is cleared. The other slots are untouched.

## Timing
- **Reset values:** all outputs are 0, all slots are invalid, state is IDLE, `last` = 3, counter = 0. Reset mid-transfer aborts immediately with no `req_ready` or `req_fail` pulse. `interboard_rst` behaves identically.
- **Latency, idle arbiter:**
  - `req_en` high at cycle 0 → `pending` at cycle 1.
  - Winner selected and fields loaded at edge 2 → `ctrl_en` = 1 during cycle 2.
  - `inter_ready` at cycle k ≥ 3 → `req_ready` at cycle k+1.
  - IDLE at cycle k+2. The next `ctrl_en` is at cycle k+3 at the earliest.
- **Timeout:** first WAIT cycle is w. With no `inter_ready`, FAIL occurs at cycle w + `TIMEOUT_CYC`. `inter_ready` arriving in the last WAIT cycle counts as success.
- Exactly one `ctrl_en` per grant. `req_ready` and `req_fail` are mutually exclusive, and each is one-hot.

## Test plan
- **Single move request:**
  - Stimulus: `req_en` = 0001 with x = 7, y = 2, msg_type = 3, card = 12 at cycle 0; `inter_ready` at cycle 5.
  - Required: `ctrl_en` in cycle 2 only, with `ctrl_block_x` = 7, `ctrl_block_y` = 2, `ctrl_card` = 12; `req_ready` = 0001 in cycle 6; `busy` low from cycle 7.
- **Simultaneous requests:**
  - Stimulus: `req_en` = 1111 in the same cycle; answer each `ctrl_en` with `inter_ready` 2 cycles later.
  - Required: grants in order 0, 1, 2, 3; then a new request from 0 and 2 is granted 0, then 2.
- **Round-robin fairness:**
  - Stimulus: requesters 0 and 1 re-request in every DONE cycle.
  - Required: grants alternate 0, 1, 0, 1 with no starvation, and `err_overflow` stays 0.
- **Overflow:**
  - Stimulus: requester 2 pulses twice while its first request waits (e.g. card = 5, then card = 9).
  - Required: `err_overflow` = 1; transmitted `ctrl_card` = 5; only one `req_ready[2]`.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYC` = 8, no `inter_ready`.
  - Required: `req_fail` pulse exactly 8 cycles after the first WAIT cycle; `err_timeout` = 1; the next pending request is then granted normally.
- **Reset mid-WAIT:**
  - Stimulus: assert `rst` during WAIT with 3 slots pending.
  - Required: next cycle all outputs are 0 and `pending` = 0000; a late `inter_ready` produces no pulse.
